// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor : gshare 2-bit-counter conditional branch predictor (Y86-64)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_predictor #(
  parameter int IDX_BITS  = 6,
  parameter int HIST_BITS = 4,
  parameter int CNT_W     = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [3:0]          f_icode_i,
  input  logic [3:0]          f_ifun_i,
  input  logic [63:0]         f_pc_i,
  input  logic [63:0]         f_valC_i,
  input  logic [63:0]         f_valP_i,
  output logic [63:0]         f_predPC_o,
  output logic                f_branch_taken_o,
  output logic [IDX_BITS-1:0] f_bht_idx_o,
  input  logic [3:0]          M_icode_i,
  input  logic [3:0]          M_ifun_i,
  input  logic                M_Cnd_i,
  input  logic                M_branch_taken_i,
  input  logic [IDX_BITS-1:0] M_bht_idx_i,
  input  logic                M_update_en_i,
  output logic [CNT_W-1:0]    branch_cnt_o,
  output logic [CNT_W-1:0]    mispred_cnt_o
);

  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam int         ENTRIES = 1 << IDX_BITS;

  logic [1:0]          bht [ENTRIES];
  logic [IDX_BITS-1:0] hist_idx;
  logic [IDX_BITS-1:0] idx;
  logic                upd;
  logic                taken;
  logic [CNT_W-1:0]    branch_cnt;
  logic [CNT_W-1:0]    mispred_cnt;
  logic                unused_pc;

  assign upd       = M_update_en_i && (M_icode_i == IJXX) && (M_ifun_i != 4'h0);
  assign unused_pc = ^f_pc_i[63:IDX_BITS];

  generate
    if (HIST_BITS > 0) begin : g_hist
      logic [HIST_BITS-1:0] ghr;

      // Truncating cast drops the oldest bit; also correct for HIST_BITS == 1.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ghr <= '0;
        end else if (upd) begin
          ghr <= HIST_BITS'({ghr, M_Cnd_i});
        end
      end

      assign hist_idx = IDX_BITS'(ghr);
    end else begin : g_no_hist
      assign hist_idx = '0;
    end
  endgenerate

  // Fetch side: reads registered table state only, no write bypass.
  assign idx = f_pc_i[IDX_BITS-1:0] ^ hist_idx;

  always_comb begin
    taken = 1'b0;
    if (f_icode_i == IJXX) begin
      if (f_ifun_i == 4'h0) begin
        taken = 1'b1;
      end else begin
        taken = bht[idx][1];
      end
    end
  end

  assign f_branch_taken_o = taken;
  assign f_bht_idx_o      = idx;
  assign f_predPC_o       = ((f_icode_i == ICALL) || ((f_icode_i == IJXX) && taken))
                            ? f_valC_i : f_valP_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= 2'b10;
      end
    end else if (upd) begin
      if (M_Cnd_i) begin
        if (bht[M_bht_idx_i] != 2'b11) begin
          bht[M_bht_idx_i] <= bht[M_bht_idx_i] + 2'd1;
        end
      end else begin
        if (bht[M_bht_idx_i] != 2'b00) begin
          bht[M_bht_idx_i] <= bht[M_bht_idx_i] - 2'd1;
        end
      end
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd) begin
      if (branch_cnt != '1) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if ((M_Cnd_i ^ M_branch_taken_i) && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign branch_cnt_o  = branch_cnt;
  assign mispred_cnt_o = mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic vs. a model.
`default_nettype none

module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [3:0]  f_icode, f_ifun;
  logic [63:0] f_pc, f_valC, f_valP;
  logic [63:0] f_predPC;
  logic        f_taken;
  logic [5:0]  f_idx;
  logic [3:0]  m_icode, m_ifun;
  logic        m_cnd, m_bt, m_en;
  logic [5:0]  m_idx;
  logic [31:0] branch_cnt, mispred_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          mdl_cnt [64];
  int          mdl_ghr;
  logic [31:0] mdl_branch, mdl_mispred;

  branch_predictor #(.IDX_BITS(6), .HIST_BITS(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .f_icode_i(f_icode), .f_ifun_i(f_ifun), .f_pc_i(f_pc),
    .f_valC_i(f_valC), .f_valP_i(f_valP),
    .f_predPC_o(f_predPC), .f_branch_taken_o(f_taken), .f_bht_idx_o(f_idx),
    .M_icode_i(m_icode), .M_ifun_i(m_ifun), .M_Cnd_i(m_cnd),
    .M_branch_taken_i(m_bt), .M_bht_idx_i(m_idx), .M_update_en_i(m_en),
    .branch_cnt_o(branch_cnt), .mispred_cnt_o(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit upd;
    upd = m_en && (m_icode == 4'h7) && (m_ifun != 4'h0);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 64; i++) mdl_cnt[i] = 2;
      mdl_ghr = 0;
      mdl_branch = 0;
      mdl_mispred = 0;
    end else if (upd) begin
      if (m_cnd) mdl_cnt[m_idx] = (mdl_cnt[m_idx] < 3) ? mdl_cnt[m_idx] + 1 : 3;
      else       mdl_cnt[m_idx] = (mdl_cnt[m_idx] > 0) ? mdl_cnt[m_idx] - 1 : 0;
      mdl_ghr = (mdl_ghr * 2 + int'(m_cnd)) % 16;
      if (mdl_branch != 32'hFFFF_FFFF) mdl_branch = mdl_branch + 1;
      if ((m_cnd != m_bt) && (mdl_mispred != 32'hFFFF_FFFF)) mdl_mispred = mdl_mispred + 1;
    end
    #1;
  endtask

  task automatic set_fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] pc,
                           input logic [63:0] vc, input logic [63:0] vp);
    f_icode = ic; f_ifun = fn; f_pc = pc; f_valC = vc; f_valP = vp;
    #1;
  endtask

  task automatic set_mem(input logic en, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [5:0] ix, input logic cnd, input logic bt);
    m_en = en; m_icode = ic; m_ifun = fn; m_idx = ix; m_cnd = cnd; m_bt = bt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_mem(1'b0, 4'h0, 4'h0, 6'd0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    set_fetch(4'h7, 4'h1, 64'h40, 64'h100, 64'h49);
    total++; if (f_taken !== 1'b1) begin $display("FAIL reset_taken: got %0b want 1", f_taken); bad++; end
    total++; if (f_predPC !== 64'h100) begin $display("FAIL reset_predpc: got %h want 100", f_predPC); bad++; end
    total++; if (f_idx !== 6'h00) begin $display("FAIL reset_idx: got %h want 00", f_idx); bad++; end
    total++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      $display("FAIL reset_counts: got %0d/%0d want 0/0", branch_cnt, mispred_cnt); bad++; end
  endtask

  task automatic test_saturate_down();
    set_mem(1'b1, 4'h7, 4'h1, 6'd0, 1'b0, 1'b1);
    tick(); tick(); tick();
    set_mem(1'b0, 4'h0, 4'h0, 6'd0, 1'b0, 1'b0);
    set_fetch(4'h7, 4'h1, 64'h40, 64'h100, 64'h49);
    total++; if (f_taken !== 1'b0) begin $display("FAIL sat_down_taken: got %0b want 0", f_taken); bad++; end
    total++; if (f_predPC !== 64'h49) begin $display("FAIL sat_down_predpc: got %h want 49", f_predPC); bad++; end
    total++; if (branch_cnt !== 32'd3) begin $display("FAIL sat_down_branch: got %0d want 3", branch_cnt); bad++; end
    total++; if (mispred_cnt !== 32'd3) begin $display("FAIL sat_down_mispred: got %0d want 3", mispred_cnt); bad++; end
  endtask

  // Counter 0 climbs from 00; fetch PC tracks the ghr so it keeps hitting index 0.
  task automatic test_train_up();
    set_mem(1'b1, 4'h7, 4'h2, 6'd0, 1'b1, 1'b0);
    set_fetch(4'h7, 4'h2, 64'h40, 64'h300, 64'h309);
    total++; if (f_taken !== 1'b0) begin $display("FAIL train_pre: got %0b want 0", f_taken); bad++; end
    tick();
    set_fetch(4'h7, 4'h2, 64'h41, 64'h300, 64'h309);
    total++; if (f_idx !== 6'h00 || f_taken !== 1'b0) begin
      $display("FAIL train_one: got idx=%h taken=%0b want idx=00 taken=0", f_idx, f_taken); bad++; end
    tick();
    set_mem(1'b0, 4'h7, 4'h2, 6'd0, 1'b1, 1'b0);
    set_fetch(4'h7, 4'h2, 64'h43, 64'h300, 64'h309);
    total++; if (f_idx !== 6'h00 || f_taken !== 1'b1) begin
      $display("FAIL train_two: got idx=%h taken=%0b want idx=00 taken=1", f_idx, f_taken); bad++; end
    total++; if (f_predPC !== 64'h300) begin $display("FAIL train_predpc: got %h want 300", f_predPC); bad++; end
    total++; if (branch_cnt !== 32'd5 || mispred_cnt !== 32'd5) begin
      $display("FAIL train_counts: got %0d/%0d want 5/5", branch_cnt, mispred_cnt); bad++; end
  endtask

  task automatic test_history();
    logic [3:0] seq;
    rst = 1'b1; tick(); rst = 1'b0;
    seq = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      set_mem(1'b1, 4'h7, 4'h3, 6'd5, seq[i], 1'b1);
      tick();
    end
    set_mem(1'b0, 4'h0, 4'h0, 6'd0, 1'b0, 1'b0);
    set_fetch(4'h7, 4'h3, 64'h40, 64'h500, 64'h509);
    total++; if (f_idx !== 6'h0B) begin $display("FAIL hist_idx: got %h want 0b", f_idx); bad++; end
    total++; if (f_taken !== 1'b1) begin $display("FAIL hist_taken: got %0b want 1", f_taken); bad++; end
    set_fetch(4'h7, 4'h3, 64'h4E, 64'h500, 64'h509);
    total++; if (f_idx !== 6'h05 || f_taken !== 1'b1) begin
      $display("FAIL hist_idx5: got idx=%h taken=%0b want idx=05 taken=1", f_idx, f_taken); bad++; end
  endtask

  task automatic test_call_jmp();
    set_fetch(4'h8, 4'h0, 64'h40, 64'h200, 64'h49);
    total++; if (f_predPC !== 64'h200 || f_taken !== 1'b0) begin
      $display("FAIL call: got pc=%h taken=%0b want pc=200 taken=0", f_predPC, f_taken); bad++; end
    set_fetch(4'h6, 4'h0, 64'h40, 64'h200, 64'h42);
    total++; if (f_predPC !== 64'h42 || f_taken !== 1'b0) begin
      $display("FAIL nonbranch: got pc=%h taken=%0b want pc=42 taken=0", f_predPC, f_taken); bad++; end
    set_fetch(4'h7, 4'h0, 64'h40, 64'h280, 64'h49);
    total++; if (f_predPC !== 64'h280 || f_taken !== 1'b1) begin
      $display("FAIL jmp: got pc=%h taken=%0b want pc=280 taken=1", f_predPC, f_taken); bad++; end
    set_mem(1'b1, 4'h7, 4'h0, 6'h0B, 1'b0, 1'b1);
    tick();
    set_mem(1'b1, 4'h8, 4'h0, 6'h0B, 1'b0, 1'b1);
    tick();
    set_mem(1'b0, 4'h0, 4'h0, 6'd0, 1'b0, 1'b0);
    set_fetch(4'h7, 4'h3, 64'h40, 64'h500, 64'h509);
    total++; if (f_idx !== 6'h0B || f_taken !== 1'b1) begin
      $display("FAIL jmp_noupd: got idx=%h taken=%0b want idx=0b taken=1", f_idx, f_taken); bad++; end
    total++; if (branch_cnt !== 32'd4) begin $display("FAIL jmp_nocount: got %0d want 4", branch_cnt); bad++; end
  endtask

  task automatic test_reset_priority();
    set_mem(1'b1, 4'h7, 4'h1, 6'd0, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_fetch(4'h7, 4'h1, 64'h40, 64'h100, 64'h49);
    total++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      $display("FAIL rstprio_counts: got %0d/%0d want 0/0", branch_cnt, mispred_cnt); bad++; end
    total++; if (f_idx !== 6'h00 || f_taken !== 1'b1) begin
      $display("FAIL rstprio_state: got idx=%h taken=%0b want idx=00 taken=1", f_idx, f_taken); bad++; end
    set_mem(1'b0, 4'h7, 4'h1, 6'd0, 1'b0, 1'b1);
    tick(); tick();
    total++; if (f_idx !== 6'h00 || f_taken !== 1'b1 || branch_cnt !== 32'd0) begin
      $display("FAIL noen: got idx=%h taken=%0b cnt=%0d want idx=00 taken=1 cnt=0", f_idx, f_taken, branch_cnt); bad++; end
  endtask

  task automatic test_random();
    logic [5:0]  e_idx;
    logic        e_taken;
    logic [63:0] e_pc;
    int          r;
    int          errs = 0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 3);
      f_icode = (r < 2) ? 4'h7 : (r == 2) ? 4'h8 : 4'($urandom);
      f_ifun  = 4'($urandom_range(0, 6));
      f_pc    = {$urandom, $urandom};
      f_valC  = {$urandom, $urandom};
      f_valP  = {$urandom, $urandom};
      r = $urandom_range(0, 3);
      set_mem(($urandom_range(0, 3) != 0), (r < 3) ? 4'h7 : 4'($urandom),
              4'($urandom_range(0, 6)), 6'($urandom), 1'($urandom), 1'($urandom));
      #1;
      e_idx   = 6'(int'(f_pc[5:0]) ^ mdl_ghr);
      e_taken = (f_icode == 4'h7) && ((f_ifun == 4'h0) || (mdl_cnt[e_idx] >= 2));
      e_pc    = ((f_icode == 4'h8) || e_taken) ? f_valC : f_valP;
      total++;
      if (f_idx !== e_idx || f_taken !== e_taken || f_predPC !== e_pc ||
          branch_cnt !== mdl_branch || mispred_cnt !== mdl_mispred) begin
        bad++;
        if (errs < 10)
          $display("FAIL random[%0d]: got idx=%h tk=%0b pc=%h b=%0d m=%0d want idx=%h tk=%0b pc=%h b=%0d m=%0d",
                   n, f_idx, f_taken, f_predPC, branch_cnt, mispred_cnt,
                   e_idx, e_taken, e_pc, mdl_branch, mdl_mispred);
        errs++;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    f_icode = 4'h0; f_ifun = 4'h0; f_pc = '0; f_valC = '0; f_valP = '0;
    set_mem(1'b0, 4'h0, 4'h0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) mdl_cnt[i] = 2;
    mdl_ghr = 0; mdl_branch = 0; mdl_mispred = 0;
    #1;
    test_reset();
    test_saturate_down();
    test_train_up();
    test_history();
    test_call_jmp();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic conditional-branch predictor for the Y86-64 pipeline.
- Sits in the fetch stage, upstream of PC selection.
- Produces the predicted next PC and the taken/not-taken bit; both travel down the pipe and are checked against the resolved condition in the memory stage.
- Holds a table of 2-bit saturating counters, indexed gshare-style, trained non-speculatively from memory-stage results. Also keeps branch and mispredict statistics.

Parameters:
- IDX_BITS, 6: log2 of counter-table entries (64 entries).
- HIST_BITS, 4: global history length; 0 selects pure bimodal indexing. Must be <= IDX_BITS.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- f_icode_i  in  4  icode of the instruction in fetch.
- f_ifun_i  in  4  ifun of the instruction in fetch.
- f_pc_i  in  64  PC of the instruction in fetch.
- f_valC_i  in  64  decoded constant (branch/call target).
- f_valP_i  in  64  fall-through PC.
- f_predPC_o  out  64  predicted next PC.
- f_branch_taken_o  out  1  prediction bit; piped down to the memory stage.
- f_bht_idx_o  out  IDX_BITS  table index used; piped down to the memory stage.
- M_icode_i  in  4  icode in the memory stage.
- M_ifun_i  in  4  ifun in the memory stage.
- M_Cnd_i  in  1  resolved branch condition.
- M_branch_taken_i  in  1  prediction made for this instruction.
- M_bht_idx_i  in  IDX_BITS  index captured at fetch.
- M_update_en_i  in  1  memory-stage instruction is valid (not a bubble, not stalled).
- branch_cnt_o  out  CNT_W  resolved conditional branches.
- mispred_cnt_o  out  CNT_W  mispredicted conditional branches.

Behaviour:
- Index: f_bht_idx_o = f_pc_i[IDX_BITS-1:0] XOR zero-extended ghr. The ghr is a HIST_BITS register; ghr[0] holds the newest outcome.
- Prediction is combinational in the same cycle, reading registered table state.
- If f_icode_i == IJXX and f_ifun_i == 0 (jmp): taken = 1.
- If f_icode_i == IJXX and f_ifun_i != 0: taken = counter[idx][1].
- Otherwise taken = 0.
- f_predPC_o = f_valC_i when f_icode_i == ICALL, or when f_icode_i == IJXX and taken = 1; otherwise f_valP_i.
- Update happens when M_update_en_i, M_icode_i == IJXX and M_ifun_i != 0 (this condition is called "upd"). On upd, at the clock edge:
  - counter[M_bht_idx_i] saturates up if M_Cnd_i, down if not; limits 0 and 3.
  - ghr <= {ghr[HIST_BITS-2:0], M_Cnd_i}.
  - branch_cnt increments.
  - mispred_cnt increments when M_Cnd_i ^ M_branch_taken_i.
  - Both statistics counters saturate at all-ones; they never wrap.
- Unconditional jmp and non-branch instructions never update the table, the ghr or the counters.
- Same-cycle read and write to one index: fetch sees the old counter value, with no bypass. Likewise, the ghr update becomes visible to fetch on the next cycle.
- Reset, synchronous, takes priority over upd:
  - all counters to 2'b10 (weakly taken);
  - ghr to 0;
  - branch_cnt and mispred_cnt to 0.
- Outputs under reset are combinational functions of the inputs and the reset-state tables. Example: a conditional jXX predicts taken, f_predPC_o = f_valC_i.
- A reset asserted mid-stream discards all training; there are no partial updates.
- No stall input is needed for fetch. Fetch-side outputs are pure functions of the current inputs. Pipeline registers downstream hold f_branch_taken_o and f_bht_idx_o.

Test Plan:
- Reset, then f_icode=IJXX, ifun=1, f_pc=0x40, valC=0x100, valP=0x49 -> f_branch_taken_o=1, f_predPC_o=0x100, f_bht_idx_o=0x00.
- Three upds to index 0 with M_Cnd=0, M_branch_taken=1 -> counter goes 10→01→00→00. Fetch at idx 0 then predicts not-taken, predPC=valP. branch_cnt=3, mispred_cnt=3.
- Starting from counter 00, two upds with Cnd=1 -> counter 10; the prediction flips to taken after exactly the second update edge, not before.
- HIST_BITS=4, upds with Cnd=1,0,1,1 -> ghr=4'b1011. f_pc=0x40 gives f_bht_idx_o=0x0B.
- ICALL with valC=0x200 -> predPC=0x200 and taken=0. A jmp (ifun=0) in M with update_en -> no change to counters or ghr.
- upd and rst_i asserted in the same cycle -> the post-edge state equals pure reset. update_en=0 with M_icode=IJXX -> no state change.
